hbridge_pwm_driver: RTL

//  Consumes the rover motor-command interface (per-side Forward/Backwards bits + 2-bit speed codes)
//  and drives the two H-bridge channels (EN = PWM, IN pair = direction). Sits between the motor

---
 rtl/motor_pkg.sv | 21 ++
 rtl/hbridge_channel.sv | 114 +++++++++++
 rtl/hbridge_pwm_driver.sv | 76 +++++++
 3 files changed

// File: rtl/motor_pkg.sv
// Shared types and speed-code decoding for the rover H-bridge PWM driver.
package motor_pkg;

    typedef enum logic [1:0] {COAST, FWD, REV} dirE;
    typedef enum logic [1:0] {IDLE, DRIVE, DEAD} chanStateE;

    function automatic int unsigned speedDuty(input logic [1:0] code,
                                              input int unsigned d1,
                                              input int unsigned d2,
                                              input int unsigned d3);
        int unsigned duty;
        case (code)
            2'd1:    duty = d1;
            2'd2:    duty = d2;
            2'd3:    duty = d3;
            default: duty = 0;
        endcase
        return duty;
    endfunction

endpackage

// File: rtl/hbridge_channel.sv
// One H-bridge channel: command decode, direction FSM with shoot-through dead time,
// per-period duty ramp and registered EN/IN pin generation.
module hbridge_channel
    import motor_pkg::*;
#(
    parameter int unsigned PWM_PERIOD = 100000,
    parameter int unsigned DUTY1      = 40000,
    parameter int unsigned DUTY2      = 70000,
    parameter int unsigned DUTY3      = 100000,
    parameter int unsigned DEADTIME   = 1000,
    parameter int unsigned RAMP_STEP  = 100000,
    localparam int DW = $clog2(PWM_PERIOD + 1),
    localparam int TW = $clog2(DEADTIME + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fwdReq,
    input  logic          revReq,
    input  logic [1:0]    speed,
    input  logic          tick,
    input  logic [DW-1:0] cntNext,
    output logic          en,
    output logic          inA,
    output logic          inB
);

    chanStateE     state, stateN;
    dirE           dir, dirN, cmd;
    logic [DW-1:0] dutyCur, dutyN, target;
    logic [TW-1:0] deadCnt, deadN;
    logic [31:0]   cur32, tgt32, ramped;

    always_comb begin
        cmd = COAST;
        if (fwdReq && !revReq)
            cmd = FWD;
        else if (!fwdReq && revReq)
            cmd = REV;

        target = DW'(speedDuty(speed, DUTY1, DUTY2, DUTY3));
        cur32  = 32'(dutyCur);
        tgt32  = 32'(target);
        if (tgt32 >= cur32)
            ramped = (tgt32 - cur32 > RAMP_STEP) ? cur32 + RAMP_STEP : tgt32;
        else
            ramped = (cur32 - tgt32 > RAMP_STEP) ? cur32 - RAMP_STEP : tgt32;

        stateN = state;
        dirN   = dir;
        dutyN  = dutyCur;
        deadN  = deadCnt;
        case (state)
            IDLE: begin
                if (cmd != COAST) begin
                    stateN = DRIVE;
                    dirN   = cmd;
                    dutyN  = '0;
                end
            end
            DRIVE: begin
                if (cmd == COAST) begin
                    stateN = IDLE;
                    dutyN  = '0;
                end else if (cmd != dir) begin
                    stateN = DEAD;
                    dutyN  = '0;
                    deadN  = '0;
                end else if (tick) begin
                    dutyN = DW'(ramped);
                end
            end
            DEAD: begin
                // Command changes are ignored until the full dead interval has elapsed.
                if (deadCnt == TW'(DEADTIME - 1)) begin
                    dutyN = '0;
                    if (cmd == COAST) begin
                        stateN = IDLE;
                    end else begin
                        stateN = DRIVE;
                        dirN   = cmd;
                    end
                end else begin
                    deadN = deadCnt + TW'(1);
                end
            end
            default: begin
                stateN = IDLE;
                dutyN  = '0;
            end
        endcase
    end

    // Pins reflect the post-edge state so EN and IN always change on the same clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            dir     <= COAST;
            dutyCur <= '0;
            deadCnt <= '0;
            en      <= 1'b0;
            inA     <= 1'b0;
            inB     <= 1'b0;
        end else begin
            state   <= stateN;
            dir     <= dirN;
            dutyCur <= dutyN;
            deadCnt <= deadN;
            en      <= (stateN == DRIVE) && (cntNext < dutyN);
            inA     <= (stateN == DRIVE) && (dirN == FWD);
            inB     <= (stateN == DRIVE) && (dirN == REV);
        end
    end

endmodule

// File: rtl/hbridge_pwm_driver.sv
// Two-channel H-bridge driver: input registers, shared PWM period counter,
// sticky illegal-command fault, and one hbridge_channel per side (1 = left, 2 = right).
module hbridge_pwm_driver #(
    parameter int unsigned PWM_PERIOD = 100000,
    parameter int unsigned DUTY1      = 40000,
    parameter int unsigned DUTY2      = 70000,
    parameter int unsigned DUTY3      = 100000,
    parameter int unsigned DEADTIME   = 1000,
    parameter int unsigned RAMP_STEP  = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Forward1,
    input  logic       Backwards1,
    input  logic       Forward2,
    input  logic       Backwards2,
    input  logic [1:0] speedL,
    input  logic [1:0] speedR,
    output logic       ENA,
    output logic       IN1,
    output logic       IN2,
    output logic       ENB,
    output logic       IN3,
    output logic       IN4,
    output logic       fault
);

    localparam int DW = $clog2(PWM_PERIOD + 1);

    logic          fwd1Q, rev1Q, fwd2Q, rev2Q;
    logic [1:0]    speedLQ, speedRQ;
    logic [DW-1:0] cnt, cntNext;
    logic          tick;

    assign tick    = (cnt == DW'(PWM_PERIOD - 1));
    assign cntNext = tick ? '0 : cnt + DW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd1Q   <= 1'b0;
            rev1Q   <= 1'b0;
            fwd2Q   <= 1'b0;
            rev2Q   <= 1'b0;
            speedLQ <= '0;
            speedRQ <= '0;
            cnt     <= '0;
            fault   <= 1'b0;
        end else begin
            fwd1Q   <= Forward1;
            rev1Q   <= Backwards1;
            fwd2Q   <= Forward2;
            rev2Q   <= Backwards2;
            speedLQ <= speedL;
            speedRQ <= speedR;
            cnt     <= cntNext;
            fault   <= fault | (fwd1Q & rev1Q) | (fwd2Q & rev2Q);
        end
    end

    hbridge_channel #(
        .PWM_PERIOD(PWM_PERIOD), .DUTY1(DUTY1), .DUTY2(DUTY2), .DUTY3(DUTY3),
        .DEADTIME(DEADTIME), .RAMP_STEP(RAMP_STEP)
    ) chanL (
        .clk(clk), .reset(reset), .fwdReq(fwd1Q), .revReq(rev1Q), .speed(speedLQ),
        .tick(tick), .cntNext(cntNext), .en(ENA), .inA(IN1), .inB(IN2)
    );

    hbridge_channel #(
        .PWM_PERIOD(PWM_PERIOD), .DUTY1(DUTY1), .DUTY2(DUTY2), .DUTY3(DUTY3),
        .DEADTIME(DEADTIME), .RAMP_STEP(RAMP_STEP)
    ) chanR (
        .clk(clk), .reset(reset), .fwdReq(fwd2Q), .revReq(rev2Q), .speed(speedRQ),
        .tick(tick), .cntNext(cntNext), .en(ENB), .inA(IN3), .inB(IN4)
    );

endmodule
